// File: rtl/pc_sequencer.sv
// Next-PC sequencer: redirect priority, pending redirects while imem is busy, and flush timing.
// Trap support (exception, mret, epc register) is built only when PC_SEQ_TRAP_EN is defined.
module pc_sequencer #(
    parameter int unsigned INSTR_BYTES  = 4,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exception,
    input  logic        mret,
    output logic [31:0] newPC,
    output logic        PCWrite,
    output logic        flush,
    output logic [31:0] epc
);

    typedef enum logic [1:0] {StRun, StPend, StFlush} state_e;

    localparam logic [1:0] PrioJump   = 2'd0;
    localparam logic [1:0] PrioBranch = 2'd1;
    localparam logic [1:0] PrioMret   = 2'd2;
    localparam logic [1:0] PrioExc    = 2'd3;

    // The write cycle itself is the first flush cycle, so FLUSH only covers the remainder.
    localparam logic [2:0] CntLoad      = 3'(FLUSH_CYCLES - 1);
    localparam state_e     StAfterWrite = (FLUSH_CYCLES > 1) ? StFlush : StRun;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [1:0]  pend_prio_q, pend_prio_d;

    logic        redir_req;
    logic [1:0]  redir_prio;
    logic [31:0] redir_tgt;
    logic [31:0] seq_pc;
    logic [31:0] new_pc;
    logic [31:0] sel_tgt;
    logic        pc_write;
    logic        flush_int;

    assign seq_pc = pc + 32'(INSTR_BYTES);

`ifdef PC_SEQ_TRAP_EN
    logic [31:0] epc_q;

    // Only a trap taken from RUN records epc; nested traps keep the original return address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            epc_q <= '0;
        end else if (exception && state_q == StRun) begin
            epc_q <= pc;
        end
    end

    assign epc = epc_q;
`else
    logic unused_trap;
    assign unused_trap = ^{exception, mret, TRAP_VECTOR};
    assign epc         = '0;
`endif

    // Later assignments win, giving exception > mret > branch > jump.
    always_comb begin
        redir_req  = 1'b0;
        redir_prio = PrioJump;
        redir_tgt  = jump_target;
        if (jump) begin
            redir_req = 1'b1;
        end
        if (branch_taken) begin
            redir_req  = 1'b1;
            redir_prio = PrioBranch;
            redir_tgt  = branch_target;
        end
`ifdef PC_SEQ_TRAP_EN
        if (mret) begin
            redir_req  = 1'b1;
            redir_prio = PrioMret;
            redir_tgt  = epc_q;
        end
        if (exception) begin
            redir_req  = 1'b1;
            redir_prio = PrioExc;
            redir_tgt  = TRAP_VECTOR;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_tgt_d  = pend_tgt_q;
        pend_prio_d = pend_prio_q;
        new_pc      = seq_pc;
        sel_tgt     = pend_tgt_q;
        pc_write    = 1'b0;
        flush_int   = 1'b0;

        unique case (state_q)
            StRun, StFlush: begin
                pc_write = imem_ready & ~stall;
                if (state_q == StFlush) begin
                    flush_int = 1'b1;
                    cnt_d     = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = StRun;
                    end
                end
                if (redir_req) begin
                    flush_int = 1'b1;
                    if (imem_ready) begin
                        new_pc   = redir_tgt;
                        pc_write = 1'b1;
                        state_d  = StAfterWrite;
                        cnt_d    = CntLoad;
                    end else begin
                        pc_write    = 1'b0;
                        pend_tgt_d  = redir_tgt;
                        pend_prio_d = redir_prio;
                        state_d     = StPend;
                        cnt_d       = 3'd0;
                    end
                end
            end
            StPend: begin
                flush_int = 1'b1;
                if (redir_req && redir_prio >= pend_prio_q) begin
                    sel_tgt     = redir_tgt;
                    pend_tgt_d  = redir_tgt;
                    pend_prio_d = redir_prio;
                end
                new_pc = sel_tgt;
                if (imem_ready) begin
                    pc_write = 1'b1;
                    state_d  = StAfterWrite;
                    cnt_d    = CntLoad;
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StRun;
            cnt_q       <= 3'd0;
            pend_tgt_q  <= '0;
            pend_prio_q <= PrioJump;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_tgt_q  <= pend_tgt_d;
            pend_prio_q <= pend_prio_d;
        end
    end

    assign newPC   = new_pc;
    assign PCWrite = rst & pc_write;
    assign flush   = rst & flush_int;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: table of per-cycle vectors plus reset and trap sequences.
// Expected outputs are queued when a cycle is driven and compared mid-cycle.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        stall;
    logic        imem_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exception;
    logic        mret;
    logic [31:0] newPC;
    logic        PCWrite;
    logic        flush;
    logic [31:0] epc;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .stall        (stall),
        .imem_ready   (imem_ready),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .exception    (exception),
        .mret         (mret),
        .newPC        (newPC),
        .PCWrite      (PCWrite),
        .flush        (flush),
        .epc          (epc)
    );

    typedef struct {
        logic [31:0] pc;
        logic        stall;
        logic        ready;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic        exc;
        logic        mret;
        logic [31:0] npc;
        logic        pcw;
        logic        fl;
        logic        chk_npc;
        logic [31:0] epc;
    } vec_t;

    typedef struct {
        logic [31:0] npc;
        logic        pcw;
        logic        fl;
        logic        chk_npc;
        logic [31:0] epc;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic [31:0] p, input int st, input int rd, input int br,
                                input logic [31:0] bt, input int j, input logic [31:0] jt,
                                input int ex, input int mr, input logic [31:0] npc,
                                input int pcw, input int fl, input int ck,
                                input logic [31:0] ep);
        vec_t v;
        v.pc      = p;
        v.stall   = (st != 0);
        v.ready   = (rd != 0);
        v.br      = (br != 0);
        v.bt      = bt;
        v.jmp     = (j != 0);
        v.jt      = jt;
        v.exc     = (ex != 0);
        v.mret    = (mr != 0);
        v.npc     = npc;
        v.pcw     = (pcw != 0);
        v.fl      = (fl != 0);
        v.chk_npc = (ck != 0);
        v.epc     = ep;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        pc            = v.pc;
        stall         = v.stall;
        imem_ready    = v.ready;
        branch_taken  = v.br;
        branch_target = v.bt;
        jump          = v.jmp;
        jump_target   = v.jt;
        exception     = v.exc;
        mret          = v.mret;
        e.npc         = v.npc;
        e.pcw         = v.pcw;
        e.fl          = v.fl;
        e.chk_npc     = v.chk_npc;
        e.epc         = v.epc;
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got nothing, expected an entry", tag);
            return;
        end
        e = sb.pop_front();
        cmp({tag, " PCWrite"}, 32'(PCWrite), 32'(e.pcw));
        cmp({tag, " flush"}, 32'(flush), 32'(e.fl));
        cmp({tag, " epc"}, epc, e.epc);
        if (e.chk_npc) begin
            cmp({tag, " newPC"}, newPC, e.npc);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        drive(v);
        #4;
        check_out(tag);
        @(posedge clk);
        #1;
    endtask

    // Drive a cycle, drop reset mid-cycle, expect outputs forced low at once.
    task automatic reset_mid(input vec_t v, input string tag);
        drive(v);
        #2;
        rst = 1'b0;
        #2;
        check_out(tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        drive(mk(32'h100, 0, 1, 0, 0, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0));
        #4;
        check_out("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        //           pc       st rd br bt       j  jt       ex mr npc      pcw fl ck epc
        tbl.push_back(mk(32'h100, 0, 1, 0, 0,       0, 0,       0, 0, 32'h104, 1, 0, 1, 0));
        tbl.push_back(mk(32'h104, 1, 1, 0, 0,       0, 0,       0, 0, 32'h108, 0, 0, 1, 0));
        tbl.push_back(mk(32'h104, 1, 1, 0, 0,       0, 0,       0, 0, 32'h108, 0, 0, 1, 0));
        tbl.push_back(mk(32'h104, 1, 1, 0, 0,       1, 32'h200, 0, 0, 32'h200, 1, 1, 1, 0));
        tbl.push_back(mk(32'h200, 0, 1, 0, 0,       0, 0,       0, 0, 32'h204, 1, 1, 1, 0));
        tbl.push_back(mk(32'h204, 0, 1, 0, 0,       0, 0,       0, 0, 32'h208, 1, 0, 1, 0));
        tbl.push_back(mk(32'h208, 0, 1, 1, 32'h300, 1, 32'h400, 0, 0, 32'h300, 1, 1, 1, 0));
        tbl.push_back(mk(32'h300, 0, 1, 0, 0,       0, 0,       0, 0, 32'h304, 1, 1, 1, 0));
        tbl.push_back(mk(32'hFFFF_FFFC, 0, 1, 0, 0, 0, 0,       0, 0, 32'h0,   1, 0, 1, 0));
        tbl.push_back(mk(32'h10,  0, 0, 0, 0,       0, 0,       0, 0, 32'h14,  0, 0, 1, 0));
        tbl.push_back(mk(32'h14,  0, 0, 1, 32'h500, 0, 0,       0, 0, 0,       0, 1, 0, 0));
        tbl.push_back(mk(32'h14,  0, 0, 0, 0,       0, 0,       0, 0, 0,       0, 1, 0, 0));
        tbl.push_back(mk(32'h14,  0, 0, 0, 0,       1, 32'h600, 0, 0, 0,       0, 1, 0, 0));
        tbl.push_back(mk(32'h14,  0, 1, 0, 0,       0, 0,       0, 0, 32'h500, 1, 1, 1, 0));
        tbl.push_back(mk(32'h500, 0, 1, 0, 0,       0, 0,       0, 0, 32'h504, 1, 1, 1, 0));
        tbl.push_back(mk(32'h504, 0, 1, 0, 0,       0, 0,       0, 0, 32'h508, 1, 0, 1, 0));
        tbl.push_back(mk(32'h508, 0, 1, 0, 0,       1, 32'h700, 0, 0, 32'h700, 1, 1, 1, 0));
        tbl.push_back(mk(32'h700, 0, 1, 1, 32'h800, 0, 0,       0, 0, 32'h800, 1, 1, 1, 0));
        tbl.push_back(mk(32'h800, 0, 1, 0, 0,       0, 0,       0, 0, 32'h804, 1, 1, 1, 0));
        tbl.push_back(mk(32'h804, 0, 1, 0, 0,       0, 0,       0, 0, 32'h808, 1, 0, 1, 0));
        tbl.push_back(mk(32'h808, 0, 0, 0, 0,       1, 32'h900, 0, 0, 0,       0, 1, 0, 0));
        tbl.push_back(mk(32'h808, 0, 0, 1, 32'hA00, 0, 0,       0, 0, 0,       0, 1, 0, 0));
        tbl.push_back(mk(32'h808, 0, 1, 0, 0,       0, 0,       0, 0, 32'hA00, 1, 1, 1, 0));
        tbl.push_back(mk(32'hA00, 0, 1, 0, 0,       0, 0,       0, 0, 32'hA04, 1, 1, 1, 0));
        tbl.push_back(mk(32'hA04, 0, 1, 0, 0,       0, 0,       0, 0, 32'hA08, 1, 0, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset in FLUSH, then sequential fetch must resume.
        step(mk(32'hA08, 0, 1, 0, 0, 1, 32'h700, 0, 0, 32'h700, 1, 1, 1, 0), "rf_jump");
        reset_mid(mk(32'h700, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rf_reset");
        step(mk(32'h40, 0, 1, 0, 0, 0, 0, 0, 0, 32'h44, 1, 0, 1, 0), "rf_resume");

        // Reset in PEND must discard the pending target.
        step(mk(32'h44, 0, 0, 1, 32'hB00, 0, 0, 0, 0, 0, 0, 1, 0, 0), "rp_branch");
        step(mk(32'h44, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "rp_wait");
        reset_mid(mk(32'h44, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rp_reset");
        step(mk(32'h50, 0, 1, 0, 0, 0, 0, 0, 0, 32'h54, 1, 0, 1, 0), "rp_resume");

`ifdef PC_SEQ_TRAP_EN
        step(mk(32'h3C, 0, 1, 1, 32'h300, 1, 32'h400, 1, 0, 32'h80, 1, 1, 1, 0), "t_exc");
        step(mk(32'h80, 0, 1, 0, 0, 0, 0, 1, 0, 32'h80, 1, 1, 1, 32'h3C), "t_nested");
        step(mk(32'h80, 0, 1, 0, 0, 0, 0, 0, 0, 32'h84, 1, 1, 1, 32'h3C), "t_flush");
        step(mk(32'h84, 0, 1, 0, 0, 0, 0, 0, 0, 32'h88, 1, 0, 1, 32'h3C), "t_run");
        step(mk(32'h10, 0, 1, 0, 0, 0, 0, 1, 0, 32'h80, 1, 1, 1, 32'h3C), "t_exc2");
        step(mk(32'h80, 0, 1, 0, 0, 0, 0, 0, 1, 32'h10, 1, 1, 1, 32'h10), "t_mret");
        step(mk(32'h10, 0, 1, 0, 0, 0, 0, 0, 0, 32'h14, 1, 1, 1, 32'h10), "t_mflush");
        step(mk(32'h14, 0, 1, 0, 0, 0, 0, 0, 0, 32'h18, 1, 0, 1, 32'h10), "t_mrun");
        step(mk(32'h20, 0, 0, 1, 32'hC00, 0, 0, 0, 0, 0, 0, 1, 0, 32'h10), "t_pbr");
        step(mk(32'h24, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 32'h10), "t_pexc");
        step(mk(32'h24, 0, 1, 1, 32'hD00, 0, 0, 0, 0, 32'h80, 1, 1, 1, 32'h10), "t_pwrite");
        step(mk(32'h80, 0, 1, 0, 0, 0, 0, 0, 0, 32'h84, 1, 1, 1, 32'h10), "t_pflush");
        step(mk(32'h84, 0, 1, 0, 0, 0, 0, 0, 0, 32'h88, 1, 0, 1, 32'h10), "t_prun");
`else
        step(mk(32'h10, 0, 1, 0, 0, 0, 0, 1, 1, 32'h14, 1, 0, 1, 0), "n_exc");
        step(mk(32'h14, 0, 1, 0, 0, 0, 0, 0, 1, 32'h18, 1, 0, 1, 0), "n_mret");
`endif

        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
